jar_sram_host: RTL
==================

# jar_sram_host

Host-side driver for the nibble-serial 8x8 SRAM pin protocol. The block accepts parallel read/write requests on a valid/ready port and generates the SRAM clock, `we`/`oe`/`commit` strobes and 4-bit shared address/data nibble. It captures read data from the SRAM output bus. It sits in the harness or test FPGA between a host controller and the SRAM tile's `io_in`/`io_out` pins.

## Interface
- `HALF`, 1: `clk` cycles per SRAM clock phase; legal range 1..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; the request is accepted on a `clk` edge where `req_valid` and `req_ready` are both high.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  3  SRAM byte address.
- `req_wdata`  in  8  write data.
- `req_len`  in  3  read burst length minus 1 (1..8 beats).
- `rsp_valid`  out  1  one-cycle pulse per read beat.
- `rsp_data`  out  8  read byte; holds its value until the next beat.
- `rsp_last`  out  1  marks the final beat of a read; qualified by `rsp_valid`.
- `sram_clk`  out  1  drives SRAM pin 0.
- `sram_we`, `sram_oe`, `sram_commit`  out  1 each  drive SRAM pins 1, 2 and 3.
- `sram_nib`  out  4  drives SRAM pins 7:4.
- `sram_dout`  in  8  SRAM `io_out`.

## Operation
- **SRAM cycle:** phase A (`sram_clk`=0, HALF clks) followed by phase B (`sram_clk`=1, HALF clks).
  - Pins change only at the start of phase A.
  - The SRAM acts on the rising edge between A and B.
- **IDLE:** `sram_clk`, all strobes and `sram_nib` are 0. No SRAM edges are generated.
- **Write (3 SRAM cycles):**
  - `we`=1, nib=`wdata[3:0]`.
  - `we`=1, nib=`wdata[7:4]`.
  - `commit`=1, nib={0,`addr`}.
  - No `rsp_valid` is produced; completion is signalled by `req_ready` returning high.
- **Read (single):**
  - One SRAM cycle with `oe`=1, nib={0,`addr`}.
  - `sram_dout` is sampled at the last clk of phase B.
  - Then a single pulse of `rsp_valid` with `rsp_last`=1.
- **Burst read (`req_len`>0):**
  - Start cycle: `we`=`oe`=`commit`=1, nib={0,`addr`}.
  - Then `req_len`+1 stream cycles with `we`=`oe`=1 and nib=0.
  - Beat k (0-based) returns mem[(`addr`+k) mod 8], sampled in phase B of stream cycle k.
  - `rsp_last` is set on beat `req_len`.
  - `req_len`=0 uses the single-read sequence.
- **FSM:** IDLE → WR0 → WR1 → WRC → IDLE; IDLE → RD → IDLE; IDLE → BST → BSTR (×(`req_len`+1)) → IDLE.
- **Ignored fields:** `req_len` is ignored for writes. `req_valid` while busy has no effect, because ready is low.
- **Address wrap:** bursts wrap 7→0 inside the SRAM. The driver does not check or limit this.

## Timing
- **Reset values:** `req_ready`=1, `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0x00, every `sram_*` output 0.
- All outputs are registered.
- **Cycle positions:** acceptance edge is E0; a transaction has N SRAM cycles (write 3, read 1, burst `req_len`+2).
  - SRAM cycle i drives its pins from E0+2i·HALF.
  - `sram_clk` rises at E0+(2i+1)·HALF.
  - `sram_clk` falls at E0+(2i+2)·HALF.
- **Read beat k:** `rsp_data` is registered at edge E0+2(k+1)·HALF for a single read, or E0+2(k+2)·HALF for a burst. `rsp_valid` is high for the following clk only.
- **Return to idle:** `req_ready` reasserts at E0+2N·HALF, with all pins 0 in the same cycle.
- **Back-to-back:** a new request is accepted no earlier than that edge. Every request therefore begins with at least one IDLE cycle at `sram_clk`=0.
- **Reset mid-operation:** outputs go to their reset values immediately (asynchronous).
  - A write interrupted before the WRC rising edge leaves SRAM memory unmodified.
  - An interrupted read produces no further `rsp_valid`.

## Configuration
- **`JAR_SRAM_HOST_BURST_EN` defined:** burst read as described above.
- **Macro undefined:**
  - `req_len` is ignored and every read is a single read.
  - The BST/BSTR states and the beat counter are not compiled.
  - `rsp_last` is tied to 1.

## Test plan
- **Write sequence:** write 0xA5 to addr 3, HALF=1 → three SRAM cycles with nib 0x5, 0xA, 0x3 and strobes we, we, commit; `req_ready` is low for exactly 6 clks.
- **Read-back:** after the write, read addr 3 → `rsp_valid` pulse 3 clks after acceptance with `rsp_data`=0xA5 and `rsp_last`=1.
- **Burst wrap:** preload mem = 0x10..0x17, burst read addr 6 with `req_len`=3 → beats 0x16, 0x17, 0x10, 0x11; `rsp_last` on the 4th beat only. Without the macro → a single beat 0x16.
- **Back-to-back:** `req_valid` held high with two writes queued → the second is accepted only after `req_ready` returns high; no overlapping `sram_clk` edges.
- **Reset during write:** assert `rst_n`=0 during WR1 → all pins 0 immediately; a later read of that address returns its old value.
- **Slow clock:** HALF=3, single read → `sram_clk` high for 3 clks; `rsp_valid` at E0+6+1; pins stable during every `sram_clk` rising edge.

Source files
------------

// File: rtl/jar_sram_host.sv
// Host-side driver for the nibble-serial 8x8 SRAM pin protocol (valid/ready requests in, SRAM pins out).
// Define JAR_SRAM_HOST_BURST_EN to compile in burst reads; otherwise every read is a single read.
module jar_sram_host #(
  parameter int unsigned HALF = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_we_i,
  input  logic [2:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  input  logic [2:0] req_len_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_last_o,
  output logic       sram_clk_o,
  output logic       sram_we_o,
  output logic       sram_oe_o,
  output logic       sram_commit_o,
  output logic [3:0] sram_nib_o,
  input  logic [7:0] sram_dout_i
);

  localparam logic [3:0] CntMax = 4'(HALF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWr0,
    StWr1,
    StWrc,
`ifdef JAR_SRAM_HOST_BURST_EN
    StBst,
    StBstr,
`endif
    StRd
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ph_q, ph_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ready_q, ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       sclk_q, sclk_d;
  // {we, oe, commit, nib}
  logic [6:0] pins_q, pins_d;
  logic       cyc_end;

`ifdef JAR_SRAM_HOST_BURST_EN
  logic [2:0] len_q, len_d;
  logic [2:0] beat_q, beat_d;
  logic       rsp_last_q, rsp_last_d;
`else
  logic       unused_len;
  assign unused_len = ^req_len_i;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ph_d        = ph_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    cyc_end     = 1'b0;
`ifdef JAR_SRAM_HOST_BURST_EN
    len_d       = len_q;
    beat_d      = beat_q;
    rsp_last_d  = rsp_last_q;
`endif

    if (state_q == StIdle) begin
      if (req_valid_i) begin
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        cnt_d   = '0;
        ph_d    = 1'b0;
        if (req_we_i) begin
          state_d = StWr0;
`ifdef JAR_SRAM_HOST_BURST_EN
        end else if (req_len_i != 3'd0) begin
          state_d = StBst;
          len_d   = req_len_i;
`endif
        end else begin
          state_d = StRd;
        end
      end
    end else if (cnt_q == CntMax) begin
      cnt_d   = '0;
      ph_d    = ~ph_q;
      cyc_end = ph_q;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end

    // Read data is sampled on the edge that closes phase B.
    if (cyc_end) begin
      case (state_q)
        StWr0: state_d = StWr1;
        StWr1: state_d = StWrc;
        StWrc: state_d = StIdle;
        StRd: begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sram_dout_i;
`ifdef JAR_SRAM_HOST_BURST_EN
          rsp_last_d  = 1'b1;
`endif
        end
`ifdef JAR_SRAM_HOST_BURST_EN
        StBst: begin
          state_d = StBstr;
          beat_d  = '0;
        end
        StBstr: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = sram_dout_i;
          rsp_last_d  = (beat_q == len_q);
          if (beat_q == len_q) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end

    case (state_d)
      StWr0:   pins_d = {3'b100, wdata_d[3:0]};
      StWr1:   pins_d = {3'b100, wdata_d[7:4]};
      StWrc:   pins_d = {3'b001, 1'b0, addr_d};
      StRd:    pins_d = {3'b010, 1'b0, addr_d};
`ifdef JAR_SRAM_HOST_BURST_EN
      StBst:   pins_d = {3'b111, 1'b0, addr_d};
      StBstr:  pins_d = {3'b110, 4'h0};
`endif
      default: pins_d = '0;
    endcase

    sclk_d  = (state_d != StIdle) && ph_d;
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ph_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      sclk_q      <= 1'b0;
      pins_q      <= '0;
`ifdef JAR_SRAM_HOST_BURST_EN
      len_q       <= '0;
      beat_q      <= '0;
      rsp_last_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      sclk_q      <= sclk_d;
      pins_q      <= pins_d;
`ifdef JAR_SRAM_HOST_BURST_EN
      len_q       <= len_d;
      beat_q      <= beat_d;
      rsp_last_q  <= rsp_last_d;
`endif
    end
  end

  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign sram_clk_o    = sclk_q;
  assign sram_we_o     = pins_q[6];
  assign sram_oe_o     = pins_q[5];
  assign sram_commit_o = pins_q[4];
  assign sram_nib_o    = pins_q[3:0];
`ifdef JAR_SRAM_HOST_BURST_EN
  assign rsp_last_o    = rsp_last_q;
`else
  assign rsp_last_o    = 1'b1;
`endif

endmodule
